// File: rtl/led_matrix_pwm_scanner.sv
// Row-scanned LED-matrix PWM driver with frame buffer and four latched run modes (display, pixel walk, row walk, breathing).
// Latency: outputs are registered one clk after the scan counters; the first pattern appears one clk after busy rises.
// Backpressure: none; start is honoured only in IDLE, abort wins over start and completion, frame-buffer writes are always accepted.
//
// Ports: clk/rst_n (async active-low); start/abort/mode run control with busy/done status;
//        wr_en/wr_row/wr_col/wr_data frame-buffer write port; row_anode (one-hot) and
//        column_cell (column c, channel k at bit c*P_CH_NUM+k) drive the matrix pins.
// Optional: define BLANKING_EN to insert a P_BLANK_CYCLES all-dark gap at every row change.
module led_matrix_pwm_scanner #(
    parameter int P_ROW_NUM      = 8,
    parameter int P_COL_NUM      = 8,
    parameter int P_CH_NUM       = 3,
    parameter int P_PWM_BITS     = 8,
    parameter int P_TICK_DIV     = 50,
    parameter int P_BLANK_CYCLES = 16
) (
    input  logic                                                clk,
    input  logic                                                rst_n,
    input  logic                                                start,
    input  logic                                                abort,
    input  logic [1:0]                                          mode,
    input  logic                                                wr_en,
    input  logic [((P_ROW_NUM > 1) ? $clog2(P_ROW_NUM) : 1)-1:0] wr_row,
    input  logic [((P_COL_NUM > 1) ? $clog2(P_COL_NUM) : 1)-1:0] wr_col,
    input  logic [P_CH_NUM*P_PWM_BITS-1:0]                      wr_data,
    output logic [P_ROW_NUM-1:0]                                row_anode,
    output logic [P_COL_NUM*P_CH_NUM-1:0]                       column_cell,
    output logic                                                busy,
    output logic                                                done
);
    localparam int RW      = (P_ROW_NUM > 1) ? $clog2(P_ROW_NUM) : 1;
    localparam int CLW     = (P_COL_NUM > 1) ? $clog2(P_COL_NUM) : 1;
    localparam int DW      = P_CH_NUM * P_PWM_BITS;
    localparam int NCELL   = P_COL_NUM * P_CH_NUM;
    // One counter serves both the tick divider and the blank timer; the two never run together.
    localparam int CNT_MAX = (P_TICK_DIV > P_BLANK_CYCLES) ? P_TICK_DIV : P_BLANK_CYCLES;
    localparam int DCW     = $clog2(CNT_MAX + 1);

`ifdef BLANKING_EN
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_BLANK, S_DONE} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

    state_t                state;
    logic [1:0]            mode_q;
    logic [DCW-1:0]        div_cnt;
    logic [P_PWM_BITS-1:0] pwm_cnt;
    logic [RW-1:0]         row_idx;
    logic [CLW-1:0]        walk_col;
    logic [P_PWM_BITS-1:0] breath_d;
    logic                  breath_fall;
`ifdef BLANKING_EN
    logic                  fin_pend;
`endif
    logic [DW-1:0]         fb [P_ROW_NUM][P_COL_NUM];

    logic                  tick;
    logic                  row_last;
    logic                  col_last;
    logic                  run_last;
    logic                  wr_ok;
    logic [RW-1:0]         row_next;
    logic [P_ROW_NUM-1:0]  row_oh;
    logic [NCELL-1:0]      lit;

    assign tick     = (div_cnt == DCW'(P_TICK_DIV - 1));
    assign row_last = (row_idx == RW'(P_ROW_NUM - 1));
    assign col_last = (walk_col == CLW'(P_COL_NUM - 1));
    assign row_next = row_last ? '0 : row_idx + 1'b1;
    assign wr_ok    = wr_en && (int'(wr_row) < P_ROW_NUM) && (int'(wr_col) < P_COL_NUM);

    // True on the row period that ends the run (mode 0 never ends by itself).
    always_comb begin
        run_last = 1'b0;
        case (mode_q)
            2'd1:    run_last = row_last && col_last;
            2'd2:    run_last = row_last;
            2'd3:    run_last = row_last && breath_fall && (breath_d == '0);
            default: run_last = 1'b0;
        endcase
    end

    always_comb begin
        row_oh = '0;
        lit    = '0;
        for (int r = 0; r < P_ROW_NUM; r++) begin
            row_oh[r] = (row_idx == RW'(r));
        end
        for (int c = 0; c < P_COL_NUM; c++) begin
            for (int k = 0; k < P_CH_NUM; k++) begin
                case (mode_q)
                    2'd0:    lit[c*P_CH_NUM+k] = fb[row_idx][c][k*P_PWM_BITS +: P_PWM_BITS] > pwm_cnt;
                    2'd1:    lit[c*P_CH_NUM+k] = (walk_col == CLW'(c));
                    2'd2:    lit[c*P_CH_NUM+k] = 1'b1;
                    default: lit[c*P_CH_NUM+k] = breath_d > pwm_cnt;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            mode_q      <= '0;
            div_cnt     <= '0;
            pwm_cnt     <= '0;
            row_idx     <= '0;
            walk_col    <= '0;
            breath_d    <= '0;
            breath_fall <= 1'b0;
`ifdef BLANKING_EN
            fin_pend    <= 1'b0;
`endif
            row_anode   <= '0;
            column_cell <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            for (int r = 0; r < P_ROW_NUM; r++) begin
                for (int c = 0; c < P_COL_NUM; c++) begin
                    fb[r][c] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            if (wr_ok) begin
                fb[wr_row][wr_col] <= wr_data;
            end
            if (abort && (state != S_IDLE)) begin
                state       <= S_IDLE;
                busy        <= 1'b0;
                row_anode   <= '0;
                column_cell <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start && !abort) begin
                            state       <= S_RUN;
                            mode_q      <= mode;
                            div_cnt     <= '0;
                            pwm_cnt     <= '0;
                            row_idx     <= '0;
                            walk_col    <= '0;
                            breath_d    <= '0;
                            breath_fall <= 1'b0;
                            busy        <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        row_anode   <= row_oh;
                        column_cell <= lit;
                        if (!tick) begin
                            div_cnt <= div_cnt + 1'b1;
                        end else begin
                            div_cnt <= '0;
                            pwm_cnt <= pwm_cnt + 1'b1;
                            if (pwm_cnt == '1) begin
                                // Row-period wrap: step the scan position for the latched mode.
                                if (mode_q == 2'd1) begin
                                    if (col_last) begin
                                        walk_col <= '0;
                                        row_idx  <= row_next;
                                    end else begin
                                        walk_col <= walk_col + 1'b1;
                                    end
                                end else begin
                                    row_idx <= row_next;
                                end
                                // Breathing duty moves once per frame: up to full scale, then back down.
                                if ((mode_q == 2'd3) && row_last) begin
                                    if (!breath_fall) begin
                                        if (breath_d == '1) begin
                                            breath_fall <= 1'b1;
                                            breath_d    <= breath_d - 1'b1;
                                        end else begin
                                            breath_d <= breath_d + 1'b1;
                                        end
                                    end else if (breath_d != '0) begin
                                        breath_d <= breath_d - 1'b1;
                                    end
                                end
`ifdef BLANKING_EN
                                state       <= S_BLANK;
                                fin_pend    <= run_last;
                                row_anode   <= '0;
                                column_cell <= '0;
`else
                                if (run_last) begin
                                    state       <= S_DONE;
                                    done        <= 1'b1;
                                    row_anode   <= '0;
                                    column_cell <= '0;
                                end
`endif
                            end
                        end
                    end
`ifdef BLANKING_EN
                    S_BLANK: begin
                        if (div_cnt == DCW'(P_BLANK_CYCLES - 1)) begin
                            div_cnt <= '0;
                            if (fin_pend) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                            end else begin
                                // Load the new row's pattern here so the dark gap is exactly the blank length.
                                state       <= S_RUN;
                                row_anode   <= row_oh;
                                column_cell <= lit;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
`endif
                    S_DONE: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_led_matrix_pwm_scanner.sv
// Bench for led_matrix_pwm_scanner at R=4, C=4, CH=3, B=4, TICK_DIV=2 (32 clk per row period).
// Expected patterns and counts are queued when a run is started and consumed as the outputs are observed.
module tb_led_matrix_pwm_scanner;
    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic        wr_en;
    logic [1:0]  wr_row;
    logic [1:0]  wr_col;
    logic [11:0] wr_data;
    logic [3:0]  row_anode;
    logic [11:0] column_cell;
    logic        busy;
    logic        done;

    led_matrix_pwm_scanner #(
        .P_ROW_NUM(4), .P_COL_NUM(4), .P_CH_NUM(3), .P_PWM_BITS(4),
        .P_TICK_DIV(2), .P_BLANK_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
        .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .row_anode(row_anode), .column_cell(column_cell), .busy(busy), .done(done)
    );

    typedef struct {
        logic [3:0]  ra;
        logic [11:0] cc;
        int          lmin;
        int          lmax;
    } exp_t;
    typedef struct {
        logic [3:0]  ra;
        logic [11:0] cc;
        int          len;
    } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   exp_i[$];
    int   checks = 0;
    int   errors = 0;
    int   done_cnt;
    int   done_at;
    int   busy_low_at;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue_start(input logic [1:0] m);
        @(negedge clk);
        mode  = m;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic do_abort;
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
    endtask

    // Records runs of identical output patterns until busy drops or the budget expires.
    task automatic capture(input int max_cyc);
        obs_t cur;
        bit   have;
        have = 1'b0;
        cur.ra = '0; cur.cc = '0; cur.len = 0;
        obs_q.delete();
        done_cnt = 0; done_at = -1; busy_low_at = -1;
        for (int k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (have && cur.ra === row_anode && cur.cc === column_cell) begin
                cur.len++;
            end else begin
                if (have) obs_q.push_back(cur);
                cur.ra = row_anode; cur.cc = column_cell; cur.len = 1; have = 1'b1;
            end
            if (busy !== 1'b1) begin
                busy_low_at = k;
                break;
            end
        end
        if (have) obs_q.push_back(cur);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 2'd0;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (row_anode !== 4'h0) begin errors++; $display("FAIL reset_row_anode: got %h want 0", row_anode); end
        checks++; if (column_cell !== 12'h0) begin errors++; $display("FAIL reset_column_cell: got %h want 0", column_cell); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_pixel_walk;
        exp_t e;
        obs_t o;
        logic [3:0] one4;
        int idx;
        one4 = 4'b0001;
        exp_q.delete();
        e.ra = '0; e.cc = '0; e.lmin = 1; e.lmax = 2; exp_q.push_back(e);
        for (int p = 0; p < 16; p++) begin
            e.ra = one4 << (p / 4); e.cc = 12'h007 << ((p % 4) * 3); e.lmin = 31; e.lmax = 32;
            exp_q.push_back(e);
        end
        e.ra = '0; e.cc = '0; e.lmin = 1; e.lmax = 3; exp_q.push_back(e);
        issue_start(2'd1);
        capture(700);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL pixel_run_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.ra !== e.ra || o.cc !== e.cc) begin errors++; $display("FAIL pixel_pattern[%0d]: got %h/%h want %h/%h", idx, o.ra, o.cc, e.ra, e.cc); end
            checks++;
            if (o.len < e.lmin || o.len > e.lmax) begin errors++; $display("FAIL pixel_len[%0d]: got %0d want %0d..%0d", idx, o.len, e.lmin, e.lmax); end
            idx++;
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL pixel_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_at < 511 || done_at > 513) begin errors++; $display("FAIL pixel_done_time: got %0d want 512+-1", done_at); end
        checks++; if (busy_low_at !== done_at + 1) begin errors++; $display("FAIL pixel_busy_fall: got %0d want %0d", busy_low_at, done_at + 1); end
    endtask

    task automatic test_row_walk;
        exp_t e;
        obs_t o;
        logic [3:0] one4;
        int idx;
        int want_done;
        one4 = 4'b0001;
        exp_q.delete();
        e.ra = '0; e.cc = '0; e.lmin = 1; e.lmax = 2; exp_q.push_back(e);
        for (int r = 0; r < 4; r++) begin
            e.ra = one4 << r; e.cc = 12'hFFF; e.lmin = 31; e.lmax = 32; exp_q.push_back(e);
`ifdef BLANKING_EN
            if (r < 3) begin
                e.ra = '0; e.cc = '0; e.lmin = 16; e.lmax = 16; exp_q.push_back(e);
            end
`endif
        end
`ifdef BLANKING_EN
        want_done = 4 * (32 + 16);
        e.ra = '0; e.cc = '0; e.lmin = 17; e.lmax = 19; exp_q.push_back(e);
`else
        want_done = 128;
        e.ra = '0; e.cc = '0; e.lmin = 1; e.lmax = 3; exp_q.push_back(e);
`endif
        issue_start(2'd2);
        capture(400);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL row_run_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
        idx = 0;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++;
            if (o.ra !== e.ra || o.cc !== e.cc) begin errors++; $display("FAIL row_pattern[%0d]: got %h/%h want %h/%h", idx, o.ra, o.cc, e.ra, e.cc); end
            checks++;
            if (o.len < e.lmin || o.len > e.lmax) begin errors++; $display("FAIL row_len[%0d]: got %0d want %0d..%0d", idx, o.len, e.lmin, e.lmax); end
            idx++;
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL row_done_count: got %0d want 1", done_cnt); end
        checks++; if (done_at < want_done - 1 || done_at > want_done + 1) begin errors++; $display("FAIL row_done_time: got %0d want %0d+-1", done_at, want_done); end
    endtask

    task automatic test_display;
        int c2, c1, c0, rows2, stray, c0_late, dn, want, got;
        int obs[7];
        c2 = 0; c1 = 0; c0 = 0; rows2 = 0; stray = 0; c0_late = 0; dn = 0;
        @(negedge clk);
        wr_en = 1'b1; wr_row = 2'd2; wr_col = 2'd1; wr_data = 12'h8F0;
        @(negedge clk);
        wr_en = 1'b0;
        exp_i.delete();
        exp_i.push_back(16); exp_i.push_back(30); exp_i.push_back(0);
        exp_i.push_back(32); exp_i.push_back(0); exp_i.push_back(30); exp_i.push_back(0);
        issue_start(2'd0);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done === 1'b1) dn++;
            if (k >= 1 && k <= 128) begin
                if (row_anode === 4'b0100) begin
                    rows2++;
                    c2 += column_cell[5] ? 1 : 0;
                    c1 += column_cell[4] ? 1 : 0;
                    c0 += column_cell[3] ? 1 : 0;
                end else if (column_cell !== 12'h0) begin
                    stray++;
                end
                if ((column_cell & ~12'h038) !== 12'h0) stray++;
            end
            if (k >= 257 && k <= 288 && row_anode === 4'b0001) c0_late += column_cell[0] ? 1 : 0;
            if (k == 150) begin wr_en = 1'b1; wr_row = 2'd0; wr_col = 2'd0; wr_data = 12'h00F; end
            if (k == 151) wr_en = 1'b0;
        end
        obs[0] = c2; obs[1] = c1; obs[2] = c0; obs[3] = rows2; obs[4] = stray; obs[5] = c0_late; obs[6] = dn;
        for (int i = 0; i < 7; i++) begin
            want = exp_i.pop_front(); got = obs[i];
            checks++;
            if (got !== want) begin errors++; $display("FAIL display_count[%0d]: got %0d want %0d", i, got, want); end
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL display_busy: got %b want 1", busy); end
        do_abort();
        @(negedge clk);
        checks++; if (busy !== 1'b0 || row_anode !== 4'h0 || column_cell !== 12'h0) begin
            errors++; $display("FAIL display_abort: got busy %b ra %h cc %h want 0/0/0", busy, row_anode, column_cell);
        end
    endtask

    task automatic test_breathing;
        int lit_f[31];
        int bad, dn, dat, want;
        bad = 0; dn = 0; dat = -1;
        for (int f = 0; f < 31; f++) lit_f[f] = 0;
        exp_i.delete();
        for (int d = 0; d <= 15; d++) exp_i.push_back(8 * d);
        for (int d = 14; d >= 0; d--) exp_i.push_back(8 * d);
        issue_start(2'd3);
        for (int k = 0; k < 4300; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin dn++; if (dat < 0) dat = k; end
            if (k >= 1 && k <= 3968 && column_cell !== 12'h0) begin
                lit_f[(k - 1) / 128]++;
                if (column_cell !== 12'hFFF) bad++;
            end
            if (busy !== 1'b1) break;
        end
        for (int f = 0; f < 31; f++) begin
            want = exp_i.pop_front();
            checks++;
            if (lit_f[f] !== want) begin errors++; $display("FAIL breath_frame[%0d]: got %0d lit clk want %0d", f, lit_f[f], want); end
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL breath_uniform: got %0d partial patterns want 0", bad); end
        checks++; if (dn !== 1) begin errors++; $display("FAIL breath_done_count: got %0d want 1", dn); end
        checks++; if (dat < 3967 || dat > 3969) begin errors++; $display("FAIL breath_done_time: got %0d want 3968+-1", dat); end
    endtask

    task automatic test_abort;
        int dn, bz;
        dn = 0; bz = 0;
        issue_start(2'd1);
        repeat (100) @(negedge clk);
        checks++; if (busy !== 1'b1 || row_anode === 4'h0) begin errors++; $display("FAIL abort_pre_run: got busy %b ra %h want busy 1 and a lit row", busy, row_anode); end
        @(negedge clk);
        abort = 1'b1; start = 1'b1; mode = 2'd2;
        @(posedge clk);
        #1;
        abort = 1'b0; start = 1'b0;
        @(negedge clk);
        checks++; if (row_anode !== 4'h0 || column_cell !== 12'h0) begin errors++; $display("FAIL abort_outputs: got %h/%h want 0/0", row_anode, column_cell); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", busy); end
        for (int k = 0; k < 200; k++) begin
            if (done === 1'b1) dn++;
            if (busy === 1'b1) bz++;
            @(negedge clk);
        end
        checks++; if (dn !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", dn); end
        checks++; if (bz !== 0) begin errors++; $display("FAIL abort_start_ignored: got %0d busy cycles want 0", bz); end
    endtask

    task automatic test_reset_midrun;
        int litc;
        litc = 0;
        issue_start(2'd0);
        repeat (70) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || row_anode !== 4'h0 || column_cell !== 12'h0) begin
            errors++; $display("FAIL midrun_reset: got busy %b ra %h cc %h want 0/0/0", busy, row_anode, column_cell);
        end
        @(negedge clk);
        rst_n = 1'b1;
        issue_start(2'd0);
        for (int k = 0; k < 130; k++) begin
            @(negedge clk);
            if (column_cell !== 12'h0) litc++;
        end
        checks++; if (litc !== 0) begin errors++; $display("FAIL midrun_buffer_cleared: got %0d lit cycles want 0", litc); end
        do_abort();
    endtask

    initial begin
        test_reset();
`ifndef BLANKING_EN
        test_pixel_walk();
`endif
        test_row_walk();
`ifndef BLANKING_EN
        test_display();
        test_breathing();
`endif
        test_abort();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/led_matrix_pwm_scanner.md
Name: led_matrix_pwm_scanner

Overview:
Parametrised row-scanned LED-matrix driver with per-pixel, per-colour-channel PWM from an internal frame buffer. Adds four latched run modes with a start/done handshake: buffer display, single-pixel walk, row walk and global breathing. Sits between the key/control logic and the matrix pins, and supersedes the fixed 8x8 test driver.

Parameters:
P_ROW_NUM, 8, number of rows (row anodes).
P_COL_NUM, 8, number of columns.
P_CH_NUM, 3, colour channels per column cell.
P_PWM_BITS, 8, duty width per channel.
P_TICK_DIV, 50, clk cycles per PWM tick (>=1).
P_BLANK_CYCLES, 16, blanking length in clk cycles (used only with BLANKING_EN).

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle run request, sampled only in IDLE
abort  in  1  stop any run immediately
mode  in  2  0=display, 1=pixel walk, 2=row walk, 3=breathing; latched on accepted start
wr_en  in  1  frame-buffer write strobe
wr_row  in  clog2(P_ROW_NUM)  write row
wr_col  in  clog2(P_COL_NUM)  write column
wr_data  in  P_CH_NUM*P_PWM_BITS  channel duties; channel k at bits [k*P_PWM_BITS +: P_PWM_BITS]
row_anode  out  P_ROW_NUM  one-hot active-high row select
column_cell  out  P_COL_NUM*P_CH_NUM  flat; column c, channel k at bit c*P_CH_NUM+k; 1 = LED on
busy  out  1  high while not IDLE
done  out  1  one-cycle completion pulse

Behaviour:
- Reset: row_anode=0, column_cell=0, busy=0, done=0. State=IDLE. Frame buffer cleared to 0. All counters are 0.
- States: IDLE, RUN, BLANK (only with macro), DONE.
- IDLE -> RUN on start=1. Mode is latched and counters are zeroed. busy rises the next cycle. start is ignored outside IDLE.
- Tick: an internal strobe fires every P_TICK_DIV clocks in RUN.
- pwm_cnt counts 0..2^P_PWM_BITS-1, advancing on each tick.
- Row period = 2^P_PWM_BITS ticks. At wrap, the row index advances modulo P_ROW_NUM. A frame is P_ROW_NUM row periods.
- A channel is lit iff duty > pwm_cnt, compared unsigned. Duty 0 is always off. The maximum duty is on for (2^B-1)/2^B of the period.
- Outputs are registered and updated on the tick. They lag the counters by 1 clk.
- Mode 0 (display): duty comes from frame buffer[row][col]. Runs continuously and never asserts done.
- Mode 1 (pixel walk): pixel p = 0..R*C-1, each held for one row period. The row is p/C; only column p%C is lit, with all channels at full on (duty ignored). After the last pixel: DONE.
- Mode 2 (row walk): rows 0..R-1, each held for one row period. All columns and channels of the current row are fully on. Then DONE.
- Mode 3 (breathing): every channel uses a shared duty d. d starts at 0, rises by 1 per frame to 2^B-1, then falls by 1 per frame to 0, then DONE. The row scan runs normally.
- DONE: done=1 for one cycle with outputs 0, then IDLE with busy=0.
- abort=1 in any state other than IDLE: next cycle is IDLE, outputs=0, busy=0, and done is not asserted. abort has priority over start and over completion in the same cycle.
- Writes: accepted in any state, one entry per cycle. Out-of-range row or column writes are ignored. A write to the pixel currently being compared takes effect from the next clk.
- Reset mid-run: immediate return to the reset values; the buffer is cleared.

Optional Feature:
BLANKING_EN
- Defined: at every row-period wrap, enter BLANK for P_BLANK_CYCLES clocks with row_anode=0 and column_cell=0. pwm_cnt and the tick divider are held during BLANK, then RUN resumes on the next row. Each row period is lengthened by P_BLANK_CYCLES. abort is honoured during BLANK.
- Undefined: no BLANK state, and rows switch on the wrap tick with no gap.

Test Plan:
Params for all scenarios: R=4, C=4, CH=3, B=4, TICK_DIV=2, so a row period is 32 clk.
1. Reset, then mode=1 with start -> busy=1. The lit column walks 0..3 on each row, 32 clk per pixel. done pulses once about 512 clk after start, then busy=0.
2. mode=2 with start -> row_anode steps 0001, 0010, 0100, 1000, with column_cell=0xFFF during each step. done arrives after 128 clk.
3. Write [2][1]=0x8F0 (ch2=8, ch1=F, ch0=0), then mode 0 -> on row 2, col1 ch2 is high for 8 of 16 ticks, ch1 for 15 of 16, ch0 never. done stays 0.
4. Mode 3 -> lit ticks per row rise 0..15 across frames, then fall back to 0. done arrives after 31 frames (31*128 clk).
5. abort mid mode 1, plus start asserted in the same cycle -> outputs=0, busy=0 next cycle, no done pulse, and the new start is not accepted.
6. With BLANKING_EN and P_BLANK_CYCLES=16, mode 2 -> an all-zero gap of 16 clk between rows. done arrives after 4*(32+16) clk, ±1.
